// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - size encodings, FSM states, byte-enable constants and alignment helpers
package mem_access_ctrl_pkg;

  // Same encoding as the data-memory op field
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_R,
    S_DONE
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SIZE_WORD) mis = (addr_lo != 2'b00);
    if (size == SIZE_HALF) mis = addr_lo[0];
    return mis;
  endfunction

  // Clears the low address bits that a naturally aligned access of this size cannot have
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] lo;
    lo = addr_lo;
    if (size == SIZE_WORD) lo = 2'b00;
    if (size == SIZE_HALF) lo = {addr_lo[1], 1'b0};
    return lo;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - word-organised data-memory request/read-data bus
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output valid, we, addr, be, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, be, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-enable/store-lane shifting and load extract/extend
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: replicate the data so every enabled lane carries it
  always_comb begin
    be         = BE_WORD;
    wdata_lane = wdata;
    case (size)
      SIZE_BYTE: begin
        be         = BE_BYTE0 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane and sign/zero-extend it
  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = rdata;
    case (size)
      SIZE_BYTE: rdata_ext = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: rdata_ext = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store initiator; define MISALIGN_EXC_EN to trap misaligned HALF/WORD
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  mem_access_ctrl_if.master mem
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lo_q, lo_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              req_illegal;
  logic [1:0]        lo_eff;
  logic [1:0]        lane_size;
  logic [1:0]        lane_lo;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

`ifdef MISALIGN_EXC_EN
  assign req_illegal = (req_size == SIZE_RSVD) || is_misaligned(req_size, req_addr[1:0]);
  assign lo_eff      = req_addr[1:0];
`else
  assign req_illegal = (req_size == SIZE_RSVD);
  assign lo_eff      = align_lo(req_size, req_addr[1:0]);
`endif

  // The lane helper formats the incoming request in IDLE and the captured one afterwards
  assign lane_size = (state_q == S_IDLE) ? req_size : size_q;
  assign lane_lo   = (state_q == S_IDLE) ? lo_eff : lo_q;

  mem_lane_align u_lane (
    .size        (lane_size),
    .addr_lo     (lane_lo),
    .is_unsigned (uns_q),
    .wdata       (req_wdata),
    .rdata       (mem.rdata),
    .be          (lane_be),
    .wdata_lane  (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  // State register plus all registered bus and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= SIZE_WORD;
      uns_q        <= 1'b0;
      lo_q         <= 2'b00;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      cnt_q        <= 8'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lo_q         <= lo_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Next-state logic; responses are set up on the transition into DONE
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lo_d         = lo_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lo_d    = lo_eff;
          cnt_d   = 8'h0;
          if (req_illegal) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = S_ISSUE;
            mem_valid_d = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = lane_be;
            mem_wdata_d = lane_wdata;
          end
        end
      end
      S_ISSUE: begin
        if (mem.ready) begin
          mem_valid_d = 1'b0;
          if (write_q) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'h0;
          end else begin
            state_d = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.rvalid) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = lane_rdata;
        end else if (cnt_q == TMO_LAST) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem.valid  = mem_valid_q;
  assign mem.we     = mem_we_q;
  assign mem.addr   = mem_addr_q;
  assign mem.be     = mem_be_q;
  assign mem.wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a reference model
module tb_mem_access_ctrl;

  localparam int TMO = 8;
  localparam int AW  = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          rl;
    int          k;
    logic [31:0] rdata;
  } macc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  resp_t exp_resp_q[$];
  macc_t exp_mem_q[$];
  int    acc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  mem_access_ctrl_if #(.ADDR_W(AW)) mem ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem          (mem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference model: what the memory should see and what the pipeline should get back
  function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                                input int rl, input int k,
                                output logic issue, output macc_t m, output resp_t r);
    int          nb;
    logic [31:0] a, mask, v;
    logic        mis;
    nb  = (sz == 2'b00) ? 4 : (sz == 2'b10) ? 2 : 1;
    mis = (addr % nb) != 0;
    a   = addr;
`ifdef MISALIGN_EXC_EN
    issue = (sz != 2'b11) && !mis;
`else
    issue = (sz != 2'b11);
    a     = addr - (addr % nb);
    mis   = 1'b0;
`endif
    m.we = wr; m.addr = a - (a % 4); m.be = 4'(((1 << nb) - 1) << (a % 4));
    for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    m.rl = rl; m.k = k; m.rdata = rd;
    r.rdata = 32'h0; r.err = 1'b0; r.lat = 0;
    if (!issue) begin
      r.err = 1'b1;
    end else if (wr) begin
      r.lat = 1 + rl;
    end else if (k < 0 || k >= TMO) begin
      r.err = 1'b1;
      r.lat = 1 + rl + TMO;
    end else begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      v = (rd >> (8 * (a % 4))) & mask;
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
      r.rdata = v;
      r.lat = 2 + rl + k;
    end
  endfunction

  task automatic issue_req(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int rl, input int k,
                           input bit expect_resp);
    logic  iss;
    macc_t m;
    resp_t r;
    model(wr, sz, uns, addr, wd, rd, rl, k, iss, m, r);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    if (iss) exp_mem_q.push_back(m);
    if (expect_resp) exp_resp_q.push_back(r);
    for (int i = 0; i < 400 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%0d required 1", req_ready);
      finish_run();
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Response monitor: tracks acceptances and scores every resp_valid pulse
  initial begin
    resp_t e;
    int    a;
    logic  was_acc;
    forever begin
      @(negedge clk); #1;
      was_acc = rst_n && req_valid && req_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        acc_q.delete();
        continue;
      end
      if (was_acc) acc_q.push_back(cyc);
      if (mem.valid) check32("busy_req_ready", {31'b0, req_ready}, 32'h0);
      if (resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: resp_valid=1 rdata=0x%08h err=%0d required no response", resp_rdata, resp_err);
        end else begin
          e = exp_resp_q.pop_front();
          a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
          check32("resp_rdata", resp_rdata, e.rdata);
          check32("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          check32("resp_latency", 32'(cyc - a), 32'(e.lat));
        end
      end
    end
  end

  // Memory responder: checks each issued access, stalls mem_ready, returns read data
  initial begin
    macc_t m;
    mem.ready = 1'b0; mem.rvalid = 1'b0; mem.rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mem.valid) begin
        if (exp_mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_access: mem_valid=1 addr=0x%08h required no access", mem.addr);
          m.we = 1'b1; m.rl = 0; m.k = -1; m.addr = mem.addr; m.be = mem.be; m.wdata = mem.wdata; m.rdata = 32'h0;
        end else begin
          m = exp_mem_q.pop_front();
          check32("mem_we", {31'b0, mem.we}, {31'b0, m.we});
          check32("mem_addr", mem.addr, m.addr);
          check32("mem_be", {28'b0, mem.be}, {28'b0, m.be});
          if (m.we) check32("mem_wdata", mem.wdata, m.wdata);
        end
        for (int i = 0; i < m.rl; i++) begin
          @(negedge clk);
          mem.rvalid = 1'($urandom_range(0, 1));
          mem.rdata  = $urandom;
          @(posedge clk); #1;
          check32("stall_mem_valid", {31'b0, mem.valid}, 32'h1);
          check32("stall_mem_addr", mem.addr, m.addr);
          check32("stall_mem_be", {28'b0, mem.be}, {28'b0, m.be});
        end
        @(negedge clk);
        mem.rvalid = 1'b0;
        mem.ready  = 1'b1;
        @(negedge clk);
        mem.ready = 1'b0;
        if (!m.we && m.k >= 0) begin
          repeat (m.k) @(negedge clk);
          mem.rvalid = 1'b1;
          mem.rdata  = m.rdata;
          @(negedge clk);
          mem.rvalid = 1'b0;
          mem.rdata  = $urandom;
        end
      end
    end
  end

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    finish_run();
  end

  initial begin
    logic [1:0] sz;
    int         r;
    int         k;
    repeat (2) @(negedge clk);
    #1;
    check32("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check32("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check32("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_mem_valid", {31'b0, mem.valid}, 32'h0);
    check32("rst_mem_we", {31'b0, mem.we}, 32'h0);
    check32("rst_mem_addr", mem.addr, 32'h0);
    check32("rst_mem_be", {28'b0, mem.be}, 32'h0);
    check32("rst_mem_wdata", mem.wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b1);
    idle(2);
    issue_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_00A5, 32'h0, 0, 0, 1'b1);
    idle(1);
    issue_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h80FF_7F01, 0, 0, 1'b1);
    issue_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h80FF_7F01, 0, 0, 1'b1);
    idle(1);
    issue_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h8001_1234, 5, 1, 1'b1);
    idle(1);
    issue_req(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 0, -1, 1'b1);
    idle(2);
    issue_req(1'b0, 2'b00, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 0, TMO - 1, 1'b1);
    idle(1);
    issue_req(1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 32'h7654_3210, 0, 0, 1'b1);
    idle(1);
    issue_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h0000_BEEF, 32'h0, 1, 0, 1'b1);
    issue_req(1'b1, 2'b11, 1'b0, 32'h30, 32'h1111_2222, 32'h0, 0, 0, 1'b1);
    idle(2);

    // Reset in the middle of WAIT_R must abort without a response
    issue_req(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h0, 0, -1, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check32("abort_req_ready", {31'b0, req_ready}, 32'h1);
    check32("abort_mem_valid", {31'b0, mem.valid}, 32'h0);
    check32("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(TMO + 4);

    for (int t = 0; t < 80; t++) begin
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      k  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
      issue_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFF,
                $urandom, $urandom, int'($urandom_range(0, 3)), k, 1'b1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    for (int i = 0; i < 2000 && exp_resp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check32("drain_resp_q", 32'(exp_resp_q.size()), 32'h0);
    check32("drain_mem_q", 32'(exp_mem_q.size()), 32'h0);
    finish_run();
  end

endmodule
